// File: rtl/io_port_bridge.sv
// Device-side IN/OUT port bridge: OUT FIFO drained over valid/ready, IN holding register.
// Define IO_PORT_BRIDGE_LOOPBACK_EN to add a loopback input routing the FIFO into the IN register.
module io_port_bridge #(
    parameter int DATA_W    = 32,
    parameter int OUT_DEPTH = 8,
    parameter int CNT_W     = $clog2(OUT_DEPTH) + 1
) (
    input  logic              Clock,
    input  logic              Reset,
`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
    input  logic              loopback,
`endif
    input  logic              OutPortin,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              InPortout,
    output logic [DATA_W-1:0] InPortData,
    output logic [DATA_W-1:0] dev_out_data,
    output logic              dev_out_valid,
    input  logic              dev_out_ready,
    input  logic [DATA_W-1:0] dev_in_data,
    input  logic              dev_in_valid,
    output logic              dev_in_ready,
    output logic              in_avail,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_overflow,
    output logic              in_underrun
);

    localparam int PTR_W = $clog2(OUT_DEPTH);

    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] hold;
    logic              avail;
    logic              ovf;
    logic              und;
    logic              out_prev;
    logic              in_prev;

    logic              lb;
    logic              not_empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              in_free;
    logic              cap;
    logic [DATA_W-1:0] cap_data;

`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
    assign lb = loopback;
`else
    assign lb = 1'b0;
`endif

    always_comb begin
        not_empty = (count != '0);
        full      = (count == CNT_W'(OUT_DEPTH));
        push      = OutPortin && !out_prev;
        in_free   = !avail && !InPortout;
        pop       = not_empty && (lb ? in_free : dev_out_ready);
        // A push into a full FIFO still fits when the head leaves on the same edge
        wr_en     = push && (!full || pop);
        cap       = lb ? pop : (dev_in_valid && in_free);
        cap_data  = lb ? mem[rd_ptr] : dev_in_data;
    end

    assign dev_out_data  = mem[rd_ptr];
    assign dev_out_valid = not_empty && !lb;
    assign dev_in_ready  = in_free && !lb;
    assign InPortData    = hold;
    assign in_avail      = avail;
    assign out_count     = count;
    assign out_overflow  = ovf;
    assign in_underrun   = und;

    always_ff @(posedge Clock) begin
        if (!Reset && wr_en) begin
            mem[wr_ptr] <= BusMuxOut;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            hold     <= '0;
            avail    <= 1'b0;
            ovf      <= 1'b0;
            und      <= 1'b0;
            // Strobes held across reset release must not fire
            out_prev <= 1'b1;
            in_prev  <= 1'b1;
        end else begin
            out_prev <= OutPortin;
            in_prev  <= InPortout;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !pop) begin
                count <= count + 1'b1;
            end else if (!wr_en && pop) begin
                count <= count - 1'b1;
            end
            if (push && !wr_en) begin
                ovf <= 1'b1;
            end
            if (InPortout && !in_prev && !avail) begin
                und <= 1'b1;
            end
            // A capture can only coincide with a read fall when nothing was held
            if (cap) begin
                hold  <= cap_data;
                avail <= 1'b1;
            end else if (!InPortout && in_prev) begin
                avail <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_io_port_bridge.sv
// Randomized and directed bench for io_port_bridge against a queue-based reference model.
// Loopback checks are compiled in when IO_PORT_BRIDGE_LOOPBACK_EN is defined.
module tb_io_port_bridge;

    localparam int DW = 32;
    localparam int D  = 8;
    localparam int CW = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          OutPortin;
    logic [DW-1:0] BusMuxOut;
    logic          InPortout;
    logic [DW-1:0] InPortData;
    logic [DW-1:0] dev_out_data;
    logic          dev_out_valid;
    logic          dev_out_ready;
    logic [DW-1:0] dev_in_data;
    logic          dev_in_valid;
    logic          dev_in_ready;
    logic          in_avail;
    logic [CW-1:0] out_count;
    logic          out_overflow;
    logic          in_underrun;
    logic          lb_en = 1'b0;

    always #5 Clock = ~Clock;

    io_port_bridge #(.DATA_W(DW), .OUT_DEPTH(D)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
        .loopback     (lb_en),
`endif
        .OutPortin    (OutPortin),
        .BusMuxOut    (BusMuxOut),
        .InPortout    (InPortout),
        .InPortData   (InPortData),
        .dev_out_data (dev_out_data),
        .dev_out_valid(dev_out_valid),
        .dev_out_ready(dev_out_ready),
        .dev_in_data  (dev_in_data),
        .dev_in_valid (dev_in_valid),
        .dev_in_ready (dev_in_ready),
        .in_avail     (in_avail),
        .out_count    (out_count),
        .out_overflow (out_overflow),
        .in_underrun  (in_underrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: queue of pending OUT words, one held IN word, sticky flags
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_hold;
    bit            m_avail, m_ovf, m_und, m_op, m_ip;

    task automatic model_tick();
        bit            free, pop, cap, full;
        logic [DW-1:0] capd;
        if (Reset) begin
            mq.delete();
            m_hold  = '0;
            m_avail = 0;
            m_ovf   = 0;
            m_und   = 0;
            m_op    = 1;
            m_ip    = 1;
            return;
        end
        free = !m_avail && !InPortout;
        full = (mq.size() == D);
        if (lb_en) begin
            pop  = (mq.size() > 0) && free;
            cap  = pop;
            capd = pop ? mq[0] : '0;
        end else begin
            pop  = (mq.size() > 0) && dev_out_ready;
            cap  = dev_in_valid && free;
            capd = dev_in_data;
        end
        if (InPortout && !m_ip && !m_avail) m_und = 1;
        if (pop) void'(mq.pop_front());
        if (OutPortin && !m_op) begin
            if (full && !pop) m_ovf = 1;
            else mq.push_back(BusMuxOut);
        end
        if (!InPortout && m_ip) m_avail = 0;
        if (cap) begin
            m_hold  = capd;
            m_avail = 1;
        end
        m_op = OutPortin;
        m_ip = InPortout;
    endtask

    task automatic check_all();
        chk("out_valid", DW'(dev_out_valid), DW'(mq.size() != 0 && !lb_en));
        if (mq.size() != 0 && !lb_en) chk("out_data", dev_out_data, mq[0]);
        chk("out_count", DW'(out_count), DW'(mq.size()));
        chk("in_avail", DW'(in_avail), DW'(m_avail));
        chk("in_data", InPortData, m_hold);
        chk("in_ready", DW'(dev_in_ready), DW'(!m_avail && !InPortout && !lb_en));
        chk("overflow", DW'(out_overflow), DW'(m_ovf));
        chk("underrun", DW'(in_underrun), DW'(m_und));
    endtask

    task automatic cyc(input bit o, input logic [DW-1:0] d, input bit i,
                       input bit r, input bit v, input logic [DW-1:0] vd);
        OutPortin     = o;
        BusMuxOut     = d;
        InPortout     = i;
        dev_out_ready = r;
        dev_in_valid  = v;
        dev_in_data   = vd;
        @(posedge Clock);
        model_tick();
        @(negedge Clock);
        check_all();
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        cyc(1, d, 0, 0, 0, '0);
        cyc(0, d, 0, 0, 0, '0);
    endtask

    initial begin
        Reset = 1;
        cyc(0, '0, 0, 0, 0, '0);
        cyc(0, '0, 0, 0, 0, '0);
        Reset = 0;
        cyc(0, '0, 0, 0, 0, '0);
        chk("rst_count", DW'(out_count), '0);
        chk("rst_valid", DW'(dev_out_valid), '0);
        chk("rst_indata", InPortData, '0);

        // single pulse push
        cyc(1, 32'hA5, 0, 0, 0, '0);
        chk("a5_valid", DW'(dev_out_valid), 1);
        chk("a5_data", dev_out_data, 32'hA5);
        chk("a5_count", DW'(out_count), 1);
        cyc(0, '0, 0, 1, 0, '0);

        // held strobe pushes once
        repeat (5) cyc(1, 32'h11, 0, 0, 0, '0);
        chk("hold_count", DW'(out_count), 1);
        cyc(0, '0, 0, 1, 0, '0);
        chk("hold_drain", DW'(out_count), 0);
        chk("hold_valid", DW'(dev_out_valid), 0);

        // overflow and ordering
        for (int k = 1; k <= 9; k++) push_word(DW'(k));
        chk("full_count", DW'(out_count), D);
        chk("full_ovf", DW'(out_overflow), 1);
        for (int k = 1; k <= 8; k++) begin
            chk("drain_order", dev_out_data, DW'(k));
            cyc(0, '0, 0, 1, 0, '0);
        end
        chk("drain_empty", DW'(out_count), 0);
        for (int k = 0; k < 8; k++) push_word(32'h20 + DW'(k));
        cyc(1, 32'hA, 0, 1, 0, '0);
        chk("pushpop_count", DW'(out_count), D);
        for (int k = 0; k < 7; k++) cyc(0, '0, 0, 1, 0, '0);
        chk("pushpop_last", dev_out_data, 32'hA);
        cyc(0, '0, 0, 1, 0, '0);

        // IN capture and read
        cyc(0, '0, 0, 0, 1, 32'hDEADBEEF);
        chk("cap_avail", DW'(in_avail), 1);
        chk("cap_ready", DW'(dev_in_ready), 0);
        repeat (3) begin
            cyc(0, '0, 1, 0, 1, 32'hCAFE);
            chk("read_stable", InPortData, 32'hDEADBEEF);
        end
        cyc(0, '0, 0, 0, 1, 32'hCAFE);
        chk("fall_clear", DW'(in_avail), 0);
        chk("fall_keep", InPortData, 32'hDEADBEEF);
        cyc(0, '0, 0, 0, 1, 32'hCAFE);
        chk("second_cap", InPortData, 32'hCAFE);
        cyc(0, '0, 1, 0, 0, '0);
        cyc(0, '0, 0, 0, 0, '0);

        // underrun
        cyc(0, '0, 1, 0, 0, '0);
        cyc(0, '0, 0, 0, 0, '0);
        cyc(0, '0, 0, 0, 0, '0);
        chk("underrun_sticky", DW'(in_underrun), 1);

        // reset with strobe held
        for (int k = 0; k < 3; k++) push_word(32'h50 + DW'(k));
        cyc(1, 32'h66, 0, 0, 0, '0);
        Reset = 1;
        cyc(1, 32'h67, 0, 0, 0, '0);
        Reset = 0;
        repeat (3) cyc(1, 32'h68, 0, 0, 0, '0);
        chk("rst_mid_count", DW'(out_count), 0);
        chk("rst_mid_ovf", DW'(out_overflow), 0);
        chk("rst_mid_und", DW'(in_underrun), 0);
        cyc(0, '0, 0, 0, 0, '0);
        cyc(1, 32'h77, 0, 0, 0, '0);
        chk("post_rst_push", DW'(out_count), 1);
        cyc(0, '0, 0, 1, 0, '0);

`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
        lb_en = 1'b1;
        cyc(1, 32'h1234, 0, 0, 1, 32'hBAD);
        cyc(0, '0, 0, 1, 1, 32'hBAD);
        chk("lb_avail", DW'(in_avail), 1);
        chk("lb_data", InPortData, 32'h1234);
        chk("lb_outvalid", DW'(dev_out_valid), 0);
        cyc(0, '0, 1, 0, 0, '0);
        cyc(0, '0, 0, 0, 0, '0);
        lb_en = 1'b0;
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            Reset = ($urandom_range(0, 299) == 0);
`ifdef IO_PORT_BRIDGE_LOOPBACK_EN
            if ($urandom_range(0, 49) == 0) lb_en = ~lb_en;
`endif
            cyc(($urandom_range(0, 2) == 0) ? ~OutPortin : OutPortin, $urandom(),
                ($urandom_range(0, 3) == 0) ? ~InPortout : InPortout,
                $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom());
        end
        Reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
